counter_display: RTL and testbench
==================================

# counter_display

Downstream display stage for `counter_8bit`. It takes the 8-bit count `c` and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) converter. It then drives a 4-digit, common-anode 7-segment display by time-multiplexing the digits. It sits between the counter and the board display pins, and it adds no handshake back to the counter.

## Interface
- `REFRESH_DIV`, default 4: `clk` cycles each digit stays lit. Legal range is ≥2. Board builds override it (e.g. 50000).
- `clk`  in  1  system clock; all logic uses its rising edge.
- `clr`  in  1  asynchronous, active-low reset. There is one clock; reset is asynchronous and active-low.
- `c`  in  8  binary count from `counter_8bit`.
- `bcd`  out  12  last converted value: `{hundreds, tens, ones}`, one nibble each.
- `busy`  out  1  high while a conversion is in progress.
- `seg`  out  7  segment drive, active-low. `seg[0]`=a … `seg[6]`=g.
- `an`  out  4  digit enables, active-low one-hot. `an[0]` is the ones digit. `an[3]` is always 1.

## Operation
- **Reset values (`clr`=0):**
  - `bcd`=12'h000, `busy`=0, internal last-converted value=0, FSM in IDLE.
  - Refresh counter=0, digit index=0, `an`=4'b1110, `seg`=7'b1000000 (glyph "0").
- **Converter FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - If `c` ≠ last-converted, capture `c` into the binary shift register and clear the 12-bit BCD scratch.
  - Then set `busy`=1 and go to SHIFT with the iteration count at 0.
- **SHIFT:** one iteration per cycle, 8 iterations in total. Each iteration:
  - add 3 to every scratch nibble that is ≥5;
  - shift `{scratch, binary}` left by 1.
  - After the 8th iteration, go to DONE.
- **DONE:**
  - `bcd` ← scratch, last-converted ← captured value, `busy`=0.
  - Go to IDLE.
- **Changes to `c` while `busy`=1:** ignored. IDLE re-compares on its next cycle, so only the final value is guaranteed to be converted. Intermediate values may be skipped.
- **Scanner:**
  - The refresh counter counts 0 … `REFRESH_DIV`−1.
  - On wrap, the digit index advances 0→1→2→0.
  - On that same edge, `an` and `seg` are registered from the new index and the current `bcd`.
- **Blanking:**
  - Hundreds is blank when it is 0.
  - Tens is blank when both hundreds and tens are 0.
  - Ones is never blank.
  - A blank digit drives `seg`=7'h7F, with `an` still asserted.
- **Glyphs (`seg`, active-low, g…a):** 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).

## Timing
- **Conversion latency:** `c` changes and is sampled in IDLE at edge N. SHIFT occupies edges N+1…N+8. `bcd` updates and `busy` falls at edge N+9.
- **Back-to-back conversions:** earliest next capture is edge N+10, so minimum spacing is 10 cycles.
- **Display refresh:**
  - Each digit is lit for exactly `REFRESH_DIV` cycles, so a full scan takes 3×`REFRESH_DIV` cycles.
  - A new `bcd` value reaches `seg` at the next digit advance, which is at most `REFRESH_DIV` cycles after the update.
- **Reset mid-conversion:** all state returns to reset values immediately. After release, if `c`≠0, conversion restarts from IDLE.
- **Simultaneous events:** a `bcd` update and a digit advance on the same edge use the old `bcd` for that digit. The new value appears from the next advance.
- **Wrap-around:** `c` going 8'hFF→8'h00 is treated as any other change and shows "0" with leading blanks.

## Structure
- **Package `counter_display_pkg`:**
  - FSM state enum (IDLE, SHIFT, DONE).
  - 10-entry glyph constant table and the `SEG_BLANK`=7'h7F constant.
  - `AN_OFF`=4'hF.
- **Sub-module `bin2bcd_seq`:** converter FSM, ports `clk`, `clr`, `c`, `bcd`, `busy`.
- **`counter_display`:** instantiates `bin2bcd_seq` and holds the scanner, blanking and glyph lookup.

## Test plan
- Release reset with `c`=8'h00, `REFRESH_DIV`=4 → `bcd`=000, `busy` never rises, `an` cycles 1110→1101→1011 every 4 clocks. `seg`=40 on the ones digit and 7F on tens and hundreds.
- `c`=8'hCD (205) → `busy` high for 9 cycles, `bcd`=12'h205 at edge N+9. `seg` reads 12 (ones digit 5), 40 (tens digit 0, not blanked), 24 (hundreds digit 2).
- `c`=8'h07 → `bcd`=007; tens and hundreds show 7F, ones shows 78.
- `c` steps 8'h0A→8'h0B→8'hFF on consecutive cycles during a conversion → `bcd`=010 first, then `bcd`=255. 8'h0B is never shown.
- Assert `clr`=0 at the 4th SHIFT cycle of 8'hCD, then release → all outputs return to reset values immediately. After release, `bcd`=205 ten cycles after the first IDLE cycle.
- `c` going 8'hFF→8'h00 → `bcd` goes 255→000, and blanking is restored on tens and hundreds.

Source files
------------

// File: rtl/counter_display_pkg.sv
// Shared types, constants and helpers for the counter display stage:
// converter states, BCD payload layout and 7-segment glyph lookup.
package counter_display_pkg;

  localparam int unsigned BIN_W      = 8;
  localparam int unsigned BCD_W      = 12;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned AN_W       = 4;
  localparam int unsigned ITER_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  typedef struct packed {
    logic [NIB_W-1:0] hundreds;
    logic [NIB_W-1:0] tens;
    logic [NIB_W-1:0] ones;
  } bcd_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [AN_W-1:0]  AN_OFF    = 4'hF;

  // Active-low g..a patterns, entry 0 in the least significant slot.
  localparam logic [9:0][SEG_W-1:0] GLYPH_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Double-dabble correction: bump every nibble >= 5 by 3 before the shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (s[NIB_W*i +: NIB_W] >= 4'd5) begin
        r[NIB_W*i +: NIB_W] = s[NIB_W*i +: NIB_W] + 4'd3;
      end
    end
    return r;
  endfunction

  function automatic logic [SEG_W-1:0] glyph(input logic [NIB_W-1:0] d);
    return (d <= 4'd9) ? GLYPH_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3), one
// iteration per clock; re-converts whenever the input differs from the last result.
module bin2bcd_seq
  import counter_display_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [BIN_W-1:0] c,
  output logic [BCD_W-1:0] bcd,
  output logic             busy
);

  conv_state_t       state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BIN_W-1:0]  cap_q, cap_d;
  logic [BIN_W-1:0]  last_q, last_d;
  logic [BCD_W-1:0]  scratch_q, scratch_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [BCD_W-1:0]  bcd_d;
  logic              busy_d;
  logic [BCD_W-1:0]  adj;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      cap_q     <= '0;
      last_q    <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd       <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      cap_q     <= cap_d;
      last_q    <= last_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      bcd       <= bcd_d;
      busy      <= busy_d;
    end
  end

  assign adj = dd_adjust(scratch_q);

  // Next-state and datapath update for the converter.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    cap_d     = cap_q;
    last_d    = last_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    bcd_d     = bcd;
    busy_d    = busy;

    unique case (state_q)
      ST_IDLE: begin
        if (c != last_q) begin
          bin_d     = c;
          cap_d     = c;
          scratch_d = '0;
          iter_d    = '0;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {scratch_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(BIN_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = scratch_q;
        last_d  = cap_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/counter_display.sv
// Display stage for counter_8bit: converts the count to BCD and scans three
// digits of a common-anode 7-segment display with leading-zero blanking.
module counter_display
  import counter_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [BIN_W-1:0] c,
  output logic [BCD_W-1:0] bcd,
  output logic             busy,
  output logic [SEG_W-1:0] seg,
  output logic [AN_W-1:0]  an
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]       digit_q, digit_d, digit_nxt;
  logic [SEG_W-1:0] seg_d, seg_sel;
  logic [AN_W-1:0]  an_d;
  logic             wrap;
  bcd_t             digits;

  bin2bcd_seq u_bin2bcd (
    .clk  (clk),
    .clr  (clr),
    .c    (c),
    .bcd  (bcd),
    .busy (busy)
  );

  assign digits    = bcd_t'(bcd);
  assign wrap      = (refresh_q == CNT_W'(REFRESH_DIV - 1));
  assign digit_nxt = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;

  // Glyph for the digit about to be lit; blanks leading zeros.
  always_comb begin
    seg_sel = glyph(digits.ones);
    unique case (digit_nxt)
      2'd1:    seg_sel = (digits.hundreds == '0 && digits.tens == '0) ? SEG_BLANK
                                                                      : glyph(digits.tens);
      2'd2:    seg_sel = (digits.hundreds == '0) ? SEG_BLANK : glyph(digits.hundreds);
      default: seg_sel = glyph(digits.ones);
    endcase
  end

  always_comb begin
    refresh_d = refresh_q + CNT_W'(1);
    digit_d   = digit_q;
    seg_d     = seg;
    an_d      = an;
    if (wrap) begin
      refresh_d = '0;
      digit_d   = digit_nxt;
      seg_d     = seg_sel;
      an_d      = AN_OFF ^ (AN_W'(1) << digit_nxt);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      refresh_q <= '0;
      digit_q   <= 2'd0;
      seg       <= GLYPH_TABLE[0];
      an        <= 4'b1110;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      seg       <= seg_d;
      an        <= an_d;
    end
  end

endmodule

// File: tb/tb_counter_display.sv
// Directed, table-driven bench for counter_display with REFRESH_DIV = 4.
module tb_counter_display;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  c   = 8'h00;
  logic [11:0] bcd;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_cmp  = 0;
  int n_fail = 0;
  bit saw_011 = 1'b0;

  typedef struct {
    logic [7:0]  c;
    logic [11:0] bcd;
    logic [6:0]  s0;
    logic [6:0]  s1;
    logic [6:0]  s2;
  } vec_t;

  vec_t vecs[9];

  counter_display #(.REFRESH_DIV(DIV)) dut (
    .clk  (clk),
    .clr  (clr),
    .c    (c),
    .bcd  (bcd),
    .busy (busy),
    .seg  (seg),
    .an   (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bcd === 12'h011) saw_011 = 1'b1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int k;
    k = 0;
    while (busy !== lvl && k < 40) begin
      tick();
      k++;
    end
    check(name, 32'(busy), 32'(lvl));
  endtask

  task automatic check_display(input string name, input logic [6:0] e0,
                               input logic [6:0] e1, input logic [6:0] e2);
    logic [6:0] exp_seg [3];
    logic [3:0] pat;
    int k;
    exp_seg[0] = e0;
    exp_seg[1] = e1;
    exp_seg[2] = e2;
    repeat (2 * DIV) tick();
    for (int d = 0; d < 3; d++) begin
      pat = 4'hF ^ (4'b0001 << d);
      k = 0;
      while (an !== pat && k < 4 * DIV) begin
        tick();
        k++;
      end
      check($sformatf("%s an%0d", name, d), 32'(an), 32'(pat));
      check($sformatf("%s seg%0d", name, d), 32'(seg), 32'(exp_seg[d]));
    end
  endtask

  initial begin
    vecs[0] = '{8'h07, 12'h007, 7'h78, 7'h7F, 7'h7F};
    vecs[1] = '{8'hFF, 12'h255, 7'h12, 7'h12, 7'h24};
    vecs[2] = '{8'h00, 12'h000, 7'h40, 7'h7F, 7'h7F};
    vecs[3] = '{8'h63, 12'h099, 7'h10, 7'h10, 7'h7F};
    vecs[4] = '{8'h64, 12'h100, 7'h40, 7'h40, 7'h79};
    vecs[5] = '{8'h0A, 12'h010, 7'h40, 7'h79, 7'h7F};
    vecs[6] = '{8'h2A, 12'h042, 7'h24, 7'h19, 7'h7F};
    vecs[7] = '{8'h80, 12'h128, 7'h00, 7'h24, 7'h79};
    vecs[8] = '{8'hCD, 12'h205, 7'h12, 7'h40, 7'h24};

    // Reset values while clr is held low
    clr = 1'b0;
    c   = 8'h00;
    repeat (3) tick();
    check("rst bcd", 32'(bcd), 32'h000);
    check("rst busy", 32'(busy), 32'h0);
    check("rst an", 32'(an), 32'b1110);
    check("rst seg", 32'(seg), 32'h40);

    // Idle scan with c = 0: digit advances every DIV clocks, no conversion
    clr = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      int idx;
      logic [3:0] pat;
      tick();
      idx = (k / int'(DIV)) % 3;
      pat = 4'hF ^ (4'b0001 << idx);
      check($sformatf("idle an k%0d", k), 32'(an), 32'(pat));
      check($sformatf("idle seg k%0d", k), 32'(seg), (idx == 0) ? 32'h40 : 32'h7F);
      check($sformatf("idle busy k%0d", k), 32'(busy), 32'h0);
    end

    // Conversion latency for 0xCD: busy for 9 cycles, bcd at edge N+9
    c = 8'hCD;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("lat busy k%0d", k), 32'(busy), 32'h1);
      check($sformatf("lat bcd k%0d", k), 32'(bcd), 32'h000);
    end
    tick();
    check("lat busy fall", 32'(busy), 32'h0);
    check("lat bcd", 32'(bcd), 32'h205);
    check_display("lat CD", 7'h12, 7'h40, 7'h24);

    // Table of single conversions
    for (int i = 0; i < 9; i++) begin
      c = vecs[i].c;
      wait_busy(1'b1, $sformatf("v%0d busy rise", i));
      wait_busy(1'b0, $sformatf("v%0d busy fall", i));
      check($sformatf("v%0d bcd", i), 32'(bcd), 32'(vecs[i].bcd));
      check_display($sformatf("v%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].s2);
    end

    // Input changes while busy: 0x0B skipped, 0xFF converted afterwards
    saw_011 = 1'b0;
    c = 8'h0A;
    tick();
    c = 8'h0B;
    tick();
    c = 8'hFF;
    tick();
    wait_busy(1'b0, "skip first fall");
    check("skip bcd first", 32'(bcd), 32'h010);
    wait_busy(1'b1, "skip second rise");
    wait_busy(1'b0, "skip second fall");
    check("skip bcd final", 32'(bcd), 32'h255);
    check("skip never 011", 32'(saw_011), 32'h0);

    // Reset during the 4th SHIFT cycle of 0xCD, then restart
    c = 8'hCD;
    tick();
    repeat (3) tick();
    check("mid busy before rst", 32'(busy), 32'h1);
    clr = 1'b0;
    #1;
    check("mid rst bcd", 32'(bcd), 32'h000);
    check("mid rst busy", 32'(busy), 32'h0);
    check("mid rst an", 32'(an), 32'b1110);
    check("mid rst seg", 32'(seg), 32'h40);
    tick();
    clr = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("restart busy k%0d", k), 32'(busy), 32'h1);
    end
    check("restart bcd pre", 32'(bcd), 32'h000);
    tick();
    check("restart bcd", 32'(bcd), 32'h205);
    check("restart busy fall", 32'(busy), 32'h0);
    check_display("restart", 7'h12, 7'h40, 7'h24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
